// File: rtl/apbDecode_package.sv
// Shared types for the two-port APB arbiter: bus address/data widths, port count
// and the transfer state machine encoding.
package apbDecode_package;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int APB_ARB_PORTS = 2;

   typedef logic [APB_ADDR_W-1:0] apb_addr_t;
   typedef logic [APB_DATA_W-1:0] apb_data_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } arb_state_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; src is the transfer initiator side, dst the completer side.
interface apb_if;
   import apbDecode_package::*;

   logic      psel;
   logic      penable;
   logic      pwrite;
   apb_addr_t paddr;
   apb_data_t pwdata;
   logic      pready;
   apb_data_t prdata;
   logic      pslverr;

   modport src (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport dst (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick; the winner of a tie is the port that did not finish
// the most recent transfer.
module apb_arb_rr
   import apbDecode_package::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [APB_ARB_PORTS-1:0] req,
   input  logic                     done,
   input  logic                     grant,
   output logic                     pick
);

   logic lastGrant;

   always_comb begin
      pick = 1'b0;
      if (&req) begin
         pick = ~lastGrant;
      end else if (req[1]) begin
         pick = 1'b1;
      end
   end

   // Reset value 1 lets port 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant <= 1'b1;
      end else if (done) begin
         lastGrant <= grant;
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter onto one downstream bus.
// Optional access watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter
   import apbDecode_package::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   apb_if.dst   apbReq0,
   apb_if.dst   apbReq1,
   apb_if.src   apbReg
);

   arb_state_t state;
   logic       grant;
   logic       pick;
   logic [1:0] req;
   logic       fwd_done;
   logic       tmo_done;
   logic       done;

   // Requests only matter while idle; the granted port is the only one in flight.
   assign req      = {apbReq1.psel, apbReq0.psel} & {2{state == IDLE}};
   assign fwd_done = (state == ACCESS) && apbReg.pready;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] tmo_cnt;

   assign tmo_done = (state == ACCESS) && !apbReg.pready &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_done = 1'b0;
`endif

   assign done = fwd_done || tmo_done;

   apb_arb_rr u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .done  (done),
      .grant (grant),
      .pick  (pick)
   );

   // Transfer FSM; downstream control and payload are all registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         grant          <= 1'b0;
         apbReg.psel    <= 1'b0;
         apbReg.penable <= 1'b0;
         apbReg.pwrite  <= 1'b0;
         apbReg.paddr   <= '0;
         apbReg.pwdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant          <= pick;
                  apbReg.paddr   <= pick ? apbReq1.paddr  : apbReq0.paddr;
                  apbReg.pwrite  <= pick ? apbReq1.pwrite : apbReq0.pwrite;
                  apbReg.pwdata  <= pick ? apbReq1.pwdata : apbReq0.pwdata;
                  apbReg.psel    <= 1'b1;
                  apbReg.penable <= 1'b0;
                  state          <= SETUP;
               end
            end
            SETUP: begin
               apbReg.penable <= 1'b1;
               state          <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
               tmo_cnt        <= '0;
`endif
            end
            ACCESS: begin
               if (done) begin
                  apbReg.psel    <= 1'b0;
                  apbReg.penable <= 1'b0;
                  state          <= IDLE;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            default: begin
               apbReg.psel    <= 1'b0;
               apbReg.penable <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

   // Completion is steered to the granted port only; a watchdog completion reports an error with no data.
   always_comb begin
      apbReq0.pready  = 1'b0;
      apbReq0.prdata  = '0;
      apbReq0.pslverr = 1'b0;
      apbReq1.pready  = 1'b0;
      apbReq1.prdata  = '0;
      apbReq1.pslverr = 1'b0;
      if (done) begin
         if (grant) begin
            apbReq1.pready  = 1'b1;
            apbReq1.prdata  = fwd_done ? apbReg.prdata : '0;
            apbReq1.pslverr = fwd_done ? apbReg.pslverr : 1'b1;
         end else begin
            apbReq0.pready  = 1'b1;
            apbReq0.prdata  = fwd_done ? apbReg.prdata : '0;
            apbReq0.pslverr = fwd_done ? apbReg.pslverr : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: two requester drivers, a waiting completer and a
// spec-level arbitration model. The watchdog test is compiled in with APB_ARB_TIMEOUT_EN.
module tb_apb_arbiter;
   import apbDecode_package::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   apb_if req0_bus ();
   apb_if req1_bus ();
   apb_if reg_bus ();

   apb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .apbReq0 (req0_bus),
      .apbReq1 (req1_bus),
      .apbReg  (reg_bus)
   );

   int checks = 0;
   int errors = 0;

   // Completer behaviour and the scoreboard queues
   int          forcedWaits = -1;
   bit          neverReady = 1'b0;
   apb_data_t   dataFor[apb_addr_t];
   logic [64:0] dq0[$], dq1[$];
   logic [32:0] uq0[$], uq1[$];
   int          servedQ[$];

   // Arbitration model state
   logic      lastModel = 1'b1;
   logic      busy = 1'b0;
   logic      curPort = 1'b0;
   apb_addr_t curAddr = '0;
   logic      prevSel0 = 1'b0, prevSel1 = 1'b0, prevDsel = 1'b0;
   int        readyCnt1 = 0;
   int        accCycles = 0;
   int        lastAcc = 0;

   task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   function automatic apb_data_t complData(input apb_addr_t a);
      if (dataFor.exists(a)) return dataFor[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic complErr(input apb_addr_t a);
      return a[2];
   endfunction

   function automatic logic [32:0] expResp(input apb_addr_t a);
      if (neverReady) return {32'h0, 1'b1};
      return {complData(a), complErr(a)};
   endfunction

   task automatic driveReq(input int port, input logic sel, input logic en, input logic wr,
                           input apb_addr_t a, input apb_data_t d);
      if (port == 0) begin
         req0_bus.psel = sel; req0_bus.penable = en; req0_bus.pwrite = wr;
         req0_bus.paddr = a; req0_bus.pwdata = d;
      end else begin
         req1_bus.psel = sel; req1_bus.penable = en; req1_bus.pwrite = wr;
         req1_bus.paddr = a; req1_bus.pwdata = d;
      end
   endtask

   // One complete requester transfer; returns right after the pready cycle, bus still driven.
   task automatic applyStimulus(input int port, input logic wr, input apb_addr_t a, input apb_data_t d);
      logic [64:0] dexp;
      logic [32:0] uexp;
      bit seen;
      dexp = {a, wr, d};
      uexp = expResp(a);
      if (port == 0) begin dq0.push_back(dexp); uq0.push_back(uexp); end
      else begin dq1.push_back(dexp); uq1.push_back(uexp); end
      @(posedge clk); #1;
      driveReq(port, 1'b1, 1'b0, wr, a, d);
      @(posedge clk); #1;
      driveReq(port, 1'b1, 1'b1, wr, a, d);
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = (port == 0) ? req0_bus.pready : req1_bus.pready;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_pready port=%0d actual=0 required=1", port);
      end
   endtask

   task automatic releaseReq(input int port);
      @(posedge clk); #1;
      driveReq(port, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_psel"},     reg_bus.psel, 0);
      checkOutput({tag, "_penable"},  reg_bus.penable, 0);
      checkOutput({tag, "_pwrite"},   reg_bus.pwrite, 0);
      checkOutput({tag, "_paddr"},    reg_bus.paddr, 0);
      checkOutput({tag, "_pwdata"},   reg_bus.pwdata, 0);
      checkOutput({tag, "_p0_resp"},  {req0_bus.pready, req0_bus.prdata, req0_bus.pslverr}, 0);
      checkOutput({tag, "_p1_resp"},  {req1_bus.pready, req1_bus.prdata, req1_bus.pslverr}, 0);
   endtask

   // Completer: random or forced wait states, data derived from the address
   initial begin
      int waitLeft;
      waitLeft = 0;
      reg_bus.pready = 1'b0; reg_bus.prdata = '0; reg_bus.pslverr = 1'b0;
      forever begin
         @(posedge clk); #1;
         reg_bus.pready = 1'b0; reg_bus.prdata = '0; reg_bus.pslverr = 1'b0;
         if (reg_bus.psel && !reg_bus.penable) begin
            waitLeft = (forcedWaits >= 0) ? forcedWaits : int'($urandom_range(0, 3));
         end else if (reg_bus.psel && reg_bus.penable && !neverReady) begin
            if (waitLeft == 0) begin
               reg_bus.pready  = 1'b1;
               reg_bus.prdata  = complData(reg_bus.paddr);
               reg_bus.pslverr = complErr(reg_bus.paddr);
            end else begin
               waitLeft--;
            end
         end
      end
   end

   // Monitor: downstream transfers against the arbitration model, upstream responses against the queues
   initial begin
      logic        eg;
      logic        rdy, er, anyRdy;
      apb_data_t   rd;
      logic [64:0] dexp;
      logic [32:0] uexp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            lastModel = 1'b1;
            busy = 1'b0;
         end else begin
            if (reg_bus.psel && !reg_bus.penable) begin
               eg = (prevSel0 && prevSel1) ? ~lastModel : (prevSel1 && !prevSel0);
               checkOutput("setup_gap", prevDsel, 0);
               if ((eg ? dq1.size() : dq0.size()) == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL down_unexpected port=%0d actual=setup required=none", eg);
               end else begin
                  dexp = eg ? dq1.pop_front() : dq0.pop_front();
                  checkOutput("down_xfer", {reg_bus.paddr, reg_bus.pwrite, reg_bus.pwdata}, dexp);
               end
               busy = 1'b1; curPort = eg; curAddr = reg_bus.paddr; accCycles = 0;
            end else if (reg_bus.psel && reg_bus.penable) begin
               accCycles++;
               checkOutput("addr_stable", reg_bus.paddr, curAddr);
            end
            anyRdy = 1'b0;
            for (int p = 0; p < 2; p++) begin
               rdy = (p == 0) ? req0_bus.pready  : req1_bus.pready;
               rd  = (p == 0) ? req0_bus.prdata  : req1_bus.prdata;
               er  = (p == 0) ? req0_bus.pslverr : req1_bus.pslverr;
               if (rdy) begin
                  anyRdy = 1'b1;
                  if (p == 1) readyCnt1++;
                  if (!busy || ((p == 0) ? uq0.size() : uq1.size()) == 0) begin
                     checks++; errors++;
                     $display("[TB] FAIL spurious_ready port=%0d actual=1 required=0", p);
                  end else begin
                     checkOutput("ready_port", p, curPort);
                     uexp = (p == 0) ? uq0.pop_front() : uq1.pop_front();
                     checkOutput("up_resp", {rd, er}, uexp);
                  end
               end else if (!(busy && p == int'(curPort))) begin
                  checkOutput("quiet", {rd, er}, 0);
               end
            end
            if (anyRdy && busy) begin
               lastModel = curPort;
               servedQ.push_back(int'(curPort));
               lastAcc = accCycles;
               busy = 1'b0;
            end
         end
         prevSel0 = req0_bus.psel;
         prevSel1 = req1_bus.psel;
         prevDsel = reg_bus.psel;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      apb_addr_t a;
      int cnt0;
      int gap;
      driveReq(0, 0, 0, 0, '0, '0);
      driveReq(1, 0, 0, 0, '0, '0);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      #2 rst_n = 1'b1;

      // Tie straight after reset: port 0 first, then port 1
      servedQ.delete();
      fork
         begin applyStimulus(0, 1'b0, 32'h100, '0); releaseReq(0); end
         begin applyStimulus(1, 1'b0, 32'h200, '0); releaseReq(1); end
      join
      checkOutput("tie_first", servedQ.size() > 0 ? servedQ[0] : -1, 0);
      checkOutput("tie_second", servedQ.size() > 1 ? servedQ[1] : -1, 1);

      // Zero-wait write latency on port 0
      forcedWaits = 0;
      fork
         applyStimulus(0, 1'b1, 32'h10, 32'hA5A5_0001);
         begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("lat_n_psel", reg_bus.psel, 0);
            @(negedge clk);
            checkOutput("lat_n1_ctrl", {reg_bus.psel, reg_bus.penable, reg_bus.pwrite}, 3'b101);
            checkOutput("lat_n1_payload", {reg_bus.paddr, reg_bus.pwdata}, {32'h10, 32'hA5A5_0001});
            checkOutput("lat_n1_p0_ready", req0_bus.pready, 0);
            @(negedge clk);
            checkOutput("lat_n2_p0_ready", req0_bus.pready, 1);
            checkOutput("lat_n2_p1_quiet", {req1_bus.pready, req1_bus.prdata, req1_bus.pslverr}, 0);
         end
      join
      releaseReq(0);

      // Three wait states on a port 1 read
      forcedWaits = 3;
      dataFor[32'h20] = 32'h1234;
      cnt0 = readyCnt1;
      applyStimulus(1, 1'b0, 32'h20, '0);
      releaseReq(1);
      repeat (3) @(posedge clk);
      checkOutput("p1_ready_once", readyCnt1 - cnt0, 1);
      forcedWaits = -1;

      // Random concurrent traffic from both requesters
      fork
         for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin releaseReq(0); repeat (gap - 1) @(posedge clk); end
            a = $urandom; a[1:0] = 2'b00;
            applyStimulus(0, 1'($urandom_range(0, 1)), a, $urandom);
         end
         for (int j = 0; j < 30; j++) begin
            automatic int g1 = $urandom_range(0, 2);
            automatic apb_addr_t a1 = {$urandom} & 32'hFFFF_FFFC;
            if (g1 > 0) begin releaseReq(1); repeat (g1 - 1) @(posedge clk); end
            applyStimulus(1, 1'($urandom_range(0, 1)), a1, $urandom);
         end
      join
      fork
         releaseReq(0);
         releaseReq(1);
      join
      repeat (2) @(posedge clk);

      // Reset during ACCESS abandons the transfer
      forcedWaits = 50;
      dq0.push_back({32'h3C, 1'b1, 32'hDEAD_BEEF});
      @(posedge clk); #1;
      driveReq(0, 1'b1, 1'b0, 1'b1, 32'h3C, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      driveReq(0, 1'b1, 1'b1, 1'b1, 32'h3C, 32'hDEAD_BEEF);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      driveReq(0, 0, 0, 0, '0, '0);
      forcedWaits = -1;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      servedQ.delete();
      fork
         begin applyStimulus(0, 1'b0, 32'h300, '0); releaseReq(0); end
         begin applyStimulus(1, 1'b1, 32'h304, 32'h55); releaseReq(1); end
      join
      checkOutput("post_reset_tie", servedQ.size() > 0 ? servedQ[0] : -1, 0);

`ifdef APB_ARB_TIMEOUT_EN
      neverReady = 1'b1;
      applyStimulus(0, 1'b0, 32'h40, '0);
      neverReady = 1'b0;
      checkOutput("tmo_access_cycles", lastAcc, 8);
      releaseReq(0);
      applyStimulus(1, 1'b0, 32'h44, '0);
      releaseReq(1);
`endif

      repeat (4) @(posedge clk);
      checkOutput("drain_up", uq0.size() + uq1.size(), 0);
      checkOutput("drain_down", dq0.size() + dq1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning ACCESS-phase cycles before forced completion (used only with APB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port apbReq0, apb_if.dst, interface, requester 0 (arbiter acts as completer).
REQ-005 SHALL have port apbReq1, apb_if.dst, interface, requester 1.
REQ-006 SHALL have port apbReg, apb_if.src, interface, shared downstream APB bus.

Function
REQ-007 Request detect: port n requesting when psel=1 and no transfer is in flight for it.
REQ-008 FSM states IDLE, SETUP, ACCESS, encoded as package enum.
REQ-009 IDLE: if any request, latch granted port's paddr/pwrite/pwdata and go SETUP next cycle; else stay IDLE.
REQ-010 SETUP: downstream psel=1, penable=0 for exactly one cycle, then go ACCESS.
REQ-011 ACCESS: downstream psel=1, penable=1; hold until downstream pready=1.
REQ-012 In the cycle downstream pready=1: granted port's pready=1; prdata/pslverr passed combinationally from downstream; FSM goes IDLE.
REQ-013 Non-granted port: pready=0, prdata=0, pslverr=0 at all times.
REQ-014 Latency: requester setup in cycle N -> downstream setup in N+1 -> earliest requester pready in N+2 (zero-wait completer).
REQ-015 Arbitration round-robin: 1-bit lastGrant; both requesting in IDLE -> grant port != lastGrant; single request -> grant it.
REQ-016 lastGrant updated on completion only.
REQ-017 Grant held for whole transfer; a new request on the other port never preempts.
REQ-018 Back-to-back: IDLE occupies one cycle between transfers; the minimum downstream gap is one cycle with psel=0.
REQ-019 Downstream paddr/pwrite/pwdata SHALL come from registers, stable across SETUP and ACCESS.
REQ-020 Downstream outputs psel, penable are 0 in IDLE.

Reset
REQ-021 rst_n low SHALL force state IDLE and lastGrant=1 (port 0 wins first tie).
REQ-022 rst_n low SHALL set downstream psel, penable, pwrite, paddr and pwdata to 0.
REQ-023 rst_n low SHALL set upstream pready, prdata and pslverr on both ports to 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no completion signalled.

Configuration
REQ-025 Macro APB_ARB_TIMEOUT_EN defined: counter clears on ACCESS entry and increments each ACCESS cycle without pready.
REQ-026 With APB_ARB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES-1 without pready: granted port gets pready=1, pslverr=1, prdata=0; downstream psel/penable drop next cycle; FSM IDLE; lastGrant updated.
REQ-027 Without APB_ARB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely.

Structure
REQ-028 apbDecode_package SHALL hold the arbiter state enum and reuse the existing APB address/data typedefs.
REQ-029 Package SHALL hold constant APB_ARB_PORTS=2.
REQ-030 Sub-module apb_arb_rr (round-robin grant, lastGrant register) is natural; the FSM and datapath stay in apb_arbiter.

Verification
REQ-031 Port 0 write 0x10<=0xA5A5_0001, zero-wait completer -> downstream setup at N+1, port 0 pready at N+2, port 1 quiet.
REQ-032 Both ports request reads at the same cycle after reset -> port 0 served first, port 1 second; port 1 pready stays 0 until its own completion.
REQ-033 Completer inserts 3 wait states on port 1 read of 0x20 returning 0x1234 -> port 1 sees pready=1 with prdata=0x1234 exactly once; downstream address stable all ACCESS cycles.
REQ-034 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, completer never ready -> port 0 pready=1 with pslverr=1 after 8 ACCESS cycles; next request is granted normally.
REQ-035 rst_n asserted during ACCESS -> all outputs 0 asynchronously; after release, port 0 wins the first tie.
